// File: rtl/hpdmc_wrpath.sv
// DDR SDRAM write data path: sequences latency, preamble, burst and postamble,
// and drives registered DQ/DM/DQS patterns to the DDR output registers.
module hpdmc_wrpath #(
    parameter int unsigned DQ_W   = 16,
    parameter int unsigned BURST  = 4,
    parameter int unsigned WR_LAT = 2
) (
    input  logic                  sys_clk,
    input  logic                  sdram_rst,
    input  logic                  write_start,
    input  logic [2*DQ_W-1:0]     wdata,
    input  logic [2*DQ_W/8-1:0]   wmask,
    output logic                  wdata_ack,
    output logic                  busy,
    output logic [DQ_W-1:0]       dq_d0,
    output logic [DQ_W-1:0]       dq_d1,
    output logic [DQ_W/8-1:0]     dm_d0,
    output logic [DQ_W/8-1:0]     dm_d1,
    output logic [DQ_W/8-1:0]     dqs_d0,
    output logic [DQ_W/8-1:0]     dqs_d1,
    output logic                  dq_oe,
    output logic                  dqs_oe
);

    localparam int unsigned MW      = DQ_W / 8;
    localparam int unsigned CNT_MAX = (WR_LAT > BURST) ? WR_LAT : BURST;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LATENCY   = 3'd1;
    localparam logic [2:0] S_PREAMBLE  = 3'd2;
    localparam logic [2:0] S_BURST     = 3'd3;
    localparam logic [2:0] S_POSTAMBLE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DQ_W-1:0]  dq_d0_q, dq_d0_d, dq_d1_q, dq_d1_d;
    logic [MW-1:0]    dm_d0_q, dm_d0_d, dm_d1_q, dm_d1_d;
    logic [MW-1:0]    dqs_d0_q, dqs_d0_d, dqs_d1_q, dqs_d1_d;
    logic             dq_oe_q, dq_oe_d, dqs_oe_q, dqs_oe_d;

    // Sequencer: counter holds remaining cycles minus one in LATENCY/BURST.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (write_start) begin
                    state_d = S_LATENCY;
                    cnt_d   = CNT_W'(WR_LAT - 1);
                end
            end
            S_LATENCY: begin
                if (cnt_q == '0) state_d = S_PREAMBLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_PREAMBLE: begin
                state_d = S_BURST;
                cnt_d   = CNT_W'(BURST - 1);
            end
            S_BURST: begin
                if (cnt_q == '0) state_d = S_POSTAMBLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_POSTAMBLE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pad pattern for the next cycle; DQ holds its last value while undriven.
    always_comb begin
        dq_d0_d  = dq_d0_q;
        dq_d1_d  = dq_d1_q;
        dm_d0_d  = '1;
        dm_d1_d  = '1;
        dqs_d0_d = '0;
        dqs_d1_d = '0;
        dq_oe_d  = 1'b0;
        dqs_oe_d = 1'b0;
        case (state_q)
            S_BURST: begin
                dq_d0_d  = wdata[2*DQ_W-1:DQ_W];
                dq_d1_d  = wdata[DQ_W-1:0];
                dm_d0_d  = wmask[2*MW-1:MW];
                dm_d1_d  = wmask[MW-1:0];
                dqs_d0_d = '1;
                dq_oe_d  = 1'b1;
                dqs_oe_d = 1'b1;
            end
            S_PREAMBLE, S_POSTAMBLE: begin
                dqs_oe_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dq_d0_q  <= '0;
            dq_d1_q  <= '0;
            dm_d0_q  <= '0;
            dm_d1_q  <= '0;
            dqs_d0_q <= '0;
            dqs_d1_q <= '0;
            dq_oe_q  <= 1'b0;
            dqs_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dq_d0_q  <= dq_d0_d;
            dq_d1_q  <= dq_d1_d;
            dm_d0_q  <= dm_d0_d;
            dm_d1_q  <= dm_d1_d;
            dqs_d0_q <= dqs_d0_d;
            dqs_d1_q <= dqs_d1_d;
            dq_oe_q  <= dq_oe_d;
            dqs_oe_q <= dqs_oe_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign wdata_ack = (state_q == S_BURST);
    assign dq_d0     = dq_d0_q;
    assign dq_d1     = dq_d1_q;
    assign dm_d0     = dm_d0_q;
    assign dm_d1     = dm_d1_q;
    assign dqs_d0    = dqs_d0_q;
    assign dqs_d1    = dqs_d1_q;
    assign dq_oe     = dq_oe_q;
    assign dqs_oe    = dqs_oe_q;

endmodule

// File: tb/tb_hpdmc_wrpath.sv
// Directed bench for hpdmc_wrpath: default instance plus a WR_LAT=1/BURST=1 instance.
module tb_hpdmc_wrpath;

    logic        clk = 1'b0;
    logic        rst;
    logic        ws, ws1;
    logic [31:0] wd;
    logic [3:0]  mk;

    logic        ack, busy, dq_oe, dqs_oe;
    logic [15:0] dq0, dq1;
    logic [1:0]  dm0, dm1, dqs0, dqs1;

    logic        ack1, busy1, dq_oe1, dqs_oe1;
    logic [15:0] dq0_1, dq1_1;
    logic [1:0]  dm0_1, dm1_1, dqs0_1, dqs1_1;

    int n_cmp = 0;
    int n_err = 0;
    int acks;

    always #5 clk = ~clk;

    hpdmc_wrpath #(.DQ_W(16), .BURST(4), .WR_LAT(2)) u_dut (
        .sys_clk(clk), .sdram_rst(rst), .write_start(ws),
        .wdata(wd), .wmask(mk), .wdata_ack(ack), .busy(busy),
        .dq_d0(dq0), .dq_d1(dq1), .dm_d0(dm0), .dm_d1(dm1),
        .dqs_d0(dqs0), .dqs_d1(dqs1), .dq_oe(dq_oe), .dqs_oe(dqs_oe)
    );

    hpdmc_wrpath #(.DQ_W(16), .BURST(1), .WR_LAT(1)) u_dut1 (
        .sys_clk(clk), .sdram_rst(rst), .write_start(ws1),
        .wdata(wd), .wmask(mk), .wdata_ack(ack1), .busy(busy1),
        .dq_d0(dq0_1), .dq_d1(dq1_1), .dm_d0(dm0_1), .dm_d1(dm1_1),
        .dqs_d0(dqs0_1), .dqs_d1(dqs1_1), .dq_oe(dq_oe1), .dqs_oe(dqs_oe1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] e_dq0, e_dq1;
        logic [1:0]  e_dm0, e_dm1;

        rst = 1'b1; ws = 1'b0; ws1 = 1'b0; wd = 32'hDEAD_BEEF; mk = 4'hF;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dm0", 32'(dm0), 32'd0);
        check("rst_dqs_oe", 32'(dqs_oe), 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Single burst: timing and data mapping
        for (int n = 0; n < 12; n++) begin
            ws = (n == 0);
            case (n)
                4:       begin wd = 32'hA1B2_C3D4; mk = 4'b0110; end
                5:       begin wd = 32'h1111_2222; mk = 4'b1000; end
                6:       begin wd = 32'h3333_4444; mk = 4'b0001; end
                7:       begin wd = 32'h5555_6666; mk = 4'b0000; end
                default: begin wd = 32'hDEAD_BEEF; mk = 4'b1111; end
            endcase
            @(negedge clk);
            check($sformatf("t1_busy_c%0d", n), 32'(busy), 32'(n >= 1 && n <= 8));
            check($sformatf("t1_ack_c%0d", n), 32'(ack), 32'(n >= 4 && n <= 7));
            check($sformatf("t1_dq_oe_c%0d", n), 32'(dq_oe), 32'(n >= 5 && n <= 8));
            check($sformatf("t1_dqs_oe_c%0d", n), 32'(dqs_oe), 32'(n >= 4 && n <= 9));
            check($sformatf("t1_dqs0_c%0d", n), 32'(dqs0), (n >= 5 && n <= 8) ? 32'd3 : 32'd0);
            check($sformatf("t1_dqs1_c%0d", n), 32'(dqs1), 32'd0);
            if (n >= 5 && n <= 10) begin
                case (n)
                    5:       begin e_dq0 = 16'hA1B2; e_dq1 = 16'hC3D4; e_dm0 = 2'b01; e_dm1 = 2'b10; end
                    6:       begin e_dq0 = 16'h1111; e_dq1 = 16'h2222; e_dm0 = 2'b10; e_dm1 = 2'b00; end
                    7:       begin e_dq0 = 16'h3333; e_dq1 = 16'h4444; e_dm0 = 2'b00; e_dm1 = 2'b01; end
                    8:       begin e_dq0 = 16'h5555; e_dq1 = 16'h6666; e_dm0 = 2'b00; e_dm1 = 2'b00; end
                    default: begin e_dq0 = 16'h5555; e_dq1 = 16'h6666; e_dm0 = 2'b11; e_dm1 = 2'b11; end
                endcase
                check($sformatf("t1_dq0_c%0d", n), 32'(dq0), 32'(e_dq0));
                check($sformatf("t1_dq1_c%0d", n), 32'(dq1), 32'(e_dq1));
                check($sformatf("t1_dm0_c%0d", n), 32'(dm0), 32'(e_dm0));
                check($sformatf("t1_dm1_c%0d", n), 32'(dm1), 32'(e_dm1));
            end
            next_cycle();
        end

        // write_start held: second burst accepted in first IDLE cycle
        for (int n = 0; n < 21; n++) begin
            ws = (n <= 12);
            @(negedge clk);
            check($sformatf("t2_ack_c%0d", n), 32'(ack),
                  32'((n >= 4 && n <= 7) || (n >= 13 && n <= 16)));
            check($sformatf("t2_busy_c%0d", n), 32'(busy),
                  32'((n >= 1 && n <= 8) || (n >= 10 && n <= 17)));
            next_cycle();
        end

        // Pulses during PREAMBLE and POSTAMBLE are ignored
        acks = 0;
        for (int n = 0; n < 16; n++) begin
            ws = (n == 0 || n == 3 || n == 8);
            @(negedge clk);
            acks += int'(ack);
            check($sformatf("t3_ack_c%0d", n), 32'(ack), 32'(n >= 4 && n <= 7));
            check($sformatf("t3_busy_c%0d", n), 32'(busy), 32'(n >= 1 && n <= 8));
            next_cycle();
        end
        ws = 1'b0;
        check("t3_ack_count", 32'(acks), 32'd4);

        // Asynchronous reset mid-burst
        for (int n = 0; n < 6; n++) begin
            ws = (n == 0);
            wd = 32'hCAFE_F00D; mk = 4'b0000;
            next_cycle();
        end
        ws = 1'b0;
        check("t4_pre_dq_oe", 32'(dq_oe), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_ack", 32'(ack), 32'd0);
        check("t4_dq_oe", 32'(dq_oe), 32'd0);
        check("t4_dqs_oe", 32'(dqs_oe), 32'd0);
        check("t4_dqs0", 32'(dqs0), 32'd0);
        check("t4_dq0", 32'(dq0), 32'd0);
        check("t4_dq1", 32'(dq1), 32'd0);
        check("t4_dm0", 32'(dm0), 32'd0);
        check("t4_dm1", 32'(dm1), 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        acks = 0;
        for (int n = 0; n < 12; n++) begin
            ws = (n == 0);
            @(negedge clk);
            acks += int'(ack);
            check($sformatf("t4_ack_c%0d", n), 32'(ack), 32'(n >= 4 && n <= 7));
            next_cycle();
        end
        ws = 1'b0;
        check("t4_ack_count", 32'(acks), 32'd4);

        // WR_LAT=1, BURST=1 instance
        for (int n = 0; n < 8; n++) begin
            ws1 = (n == 0);
            @(negedge clk);
            check($sformatf("t5_ack_c%0d", n), 32'(ack1), 32'(n == 3));
            check($sformatf("t5_dq_oe_c%0d", n), 32'(dq_oe1), 32'(n == 4));
            check($sformatf("t5_dqs_oe_c%0d", n), 32'(dqs_oe1), 32'(n >= 3 && n <= 5));
            check($sformatf("t5_busy_c%0d", n), 32'(busy1), 32'(n >= 1 && n <= 4));
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
